// File: rtl/ringosc_pkg.sv
// Ring-oscillator measurement controller: shared types and defaults.
// Holds the FSM state encoding, default sizing constants and the
// window-length helper used by the controller.
package ringosc_pkg;

    localparam int COUNT_W_DEF       = 16;
    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int TIMER_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meas_state_e;

    // Terminal value of the down-counting window timer: 2^g - 1.
    // A 16-bit timer covers every gate_log2 value (max 2^15 - 1).
    function automatic logic [TIMER_W-1:0] window_last(input logic [3:0] g);
        window_last = (16'd1 << g) - 16'd1;
    endfunction

endpackage

// File: rtl/ringosc_meas_ctrl_if.sv
// Control/status bundle between a host and the ring-oscillator
// measurement controller. The host is the master; the controller is the slave.
interface ringosc_meas_ctrl_if
    import ringosc_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
);
    logic               start;
    logic               abort;
    logic [2:0]         tap_sel;
    logic [3:0]         gate_log2;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] count;
    logic               ovf;

    modport master (
        output start, abort, tap_sel, gate_log2,
        input  busy, done, count, ovf
    );

    modport slave (
        input  start, abort, tap_sel, gate_log2,
        output busy, done, count, ovf
    );
endinterface

// File: rtl/ringosc_edge_sync.sv
// Selects one ring tap, brings it into the clk domain through a
// 2-flop synchronizer and flags rising edges against one delay flop.
module ringosc_edge_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ring_taps,
    input  logic [2:0] tap_sel,
    output logic       rise
);

    logic tap_s;
    logic meta_r;
    logic sync_r;
    logic dly_r;

    // Pick the tap to observe; the mux output is still asynchronous.
    always_comb begin
        tap_s = ring_taps[tap_sel];
    end

    // Two synchronizer stages followed by the edge-detect delay stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            dly_r  <= 1'b0;
        end else begin
            meta_r <= tap_s;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign rise = sync_r & ~dly_r;

endmodule

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator frequency measurement controller.
// Enables the ring, lets it settle, then counts synchronized rising edges
// of one tap over a 2^gate_log2-cycle window and reports the count.
// Build option: define RINGOSC_MEAS_SAT_EN to saturate the edge counter
// and report overflow on ovf; otherwise the counter wraps and ovf is 0.
// The COUNT_W parameter must match the COUNT_W of the connected interface.
module ringosc_meas_ctrl
    import ringosc_pkg::*;
#(
    parameter int COUNT_W       = COUNT_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    ringosc_meas_ctrl_if.slave  bus,
    input  logic [7:0]          ring_taps,
    output logic                ring_en
);

    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    meas_state_e        state_r;
    meas_state_e        state_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_s;
    logic [COUNT_W-1:0] edge_cnt_r;
    logic [COUNT_W-1:0] edge_cnt_s;
    logic [COUNT_W-1:0] count_r;
    logic [2:0]         tap_sel_r;
    logic [3:0]         gate_log2_r;
    logic               ring_en_r;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic               start_ok_s;
    logic               rise_s;
`ifdef RINGOSC_MEAS_SAT_EN
    logic               sat_r;
    logic               sat_s;
`endif

    ringosc_edge_sync u_edge_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ring_taps (ring_taps),
        .tap_sel   (tap_sel_r),
        .rise      (rise_s)
    );

    assign start_ok_s = (state_r == ST_IDLE) && bus.start;

    // Next-state and phase timer: settle for a fixed time, then measure the window.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SETTLE;
                    timer_s = SETTLE_LAST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (timer_r == '0) begin
                    state_s = ST_MEASURE;
                    timer_s = window_last(gate_log2_r);
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            ST_MEASURE: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (timer_r == '0) begin
                    state_s = ST_DONE;
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = '0;
            end
        endcase
    end

    // Edge counter: cleared on an accepted start, advanced on each flagged edge in MEASURE.
    always_comb begin
        edge_cnt_s = edge_cnt_r;
`ifdef RINGOSC_MEAS_SAT_EN
        sat_s = sat_r;
        if (start_ok_s) begin
            edge_cnt_s = '0;
            sat_s      = 1'b0;
        end else if ((state_r == ST_MEASURE) && rise_s) begin
            if (&edge_cnt_r) begin
                sat_s = 1'b1;
            end else begin
                edge_cnt_s = edge_cnt_r + COUNT_W'(1);
            end
        end else begin
            sat_s = sat_r;
        end
`else
        if (start_ok_s) begin
            edge_cnt_s = '0;
        end else if ((state_r == ST_MEASURE) && rise_s) begin
            edge_cnt_s = edge_cnt_r + COUNT_W'(1);
        end else begin
            edge_cnt_s = edge_cnt_r;
        end
`endif
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            edge_cnt_r  <= '0;
            count_r     <= '0;
            tap_sel_r   <= 3'd0;
            gate_log2_r <= 4'd0;
            ring_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
`ifdef RINGOSC_MEAS_SAT_EN
            sat_r       <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            edge_cnt_r <= edge_cnt_s;
            ring_en_r  <= (state_s == ST_SETTLE) || (state_s == ST_MEASURE);
            busy_r     <= (state_s == ST_SETTLE) || (state_s == ST_MEASURE);
            done_r     <= (state_s == ST_DONE);
`ifdef RINGOSC_MEAS_SAT_EN
            sat_r      <= sat_s;
`endif
            if (start_ok_s) begin
                tap_sel_r   <= bus.tap_sel;
                gate_log2_r <= bus.gate_log2;
            end
            // DONE is only reachable from a completed window.
            if (state_s == ST_DONE) begin
                count_r <= edge_cnt_s;
`ifdef RINGOSC_MEAS_SAT_EN
                ovf_r   <= sat_s;
`else
                ovf_r   <= 1'b0;
`endif
            end
        end
    end

    assign ring_en   = ring_en_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.count = count_r;
    assign bus.ovf   = ovf_r;

endmodule

// File: doc/ringosc_meas_ctrl.md
RINGOSC_MEAS_CTRL -- requirements
Module: ringosc_meas_ctrl

Interface
REQ-001 Parameter COUNT_W, default 16: edge-counter and result width.
REQ-002 Parameter SETTLE_CYCLES, default 16: ring warm-up cycles before counting.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  measurement request; sampled in IDLE only.
REQ-006 abort  input  1  cancel the measurement in progress.
REQ-007 tap_sel  input  3  ring tap to measure; latched on accepted start.
REQ-008 gate_log2  input  4  window length = 2^gate_log2 clk cycles; latched on accepted start.
REQ-009 ring_taps  input  8  asynchronous ring-oscillator tap outputs.
REQ-010 ring_en  output  1  ring enable; drives the chain input.
REQ-011 busy  output  1  high in SETTLE and MEASURE.
REQ-012 done  output  1  one-cycle pulse when the result is valid.
REQ-013 count  output  COUNT_W  rising-edge count of the last completed window.
REQ-014 ovf  output  1  count saturated in the last window.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, MEASURE and DONE.
REQ-016 IDLE: start=1 SHALL latch tap_sel and gate_log2, clear the edge counter, and go to SETTLE the next cycle.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles with ring_en=1 and no counting, then go to MEASURE.
REQ-018 MEASURE SHALL last exactly 2^gate_log2 cycles; each cycle a synchronized rising edge is flagged on the selected tap, the counter SHALL increment by 1.
REQ-019 The selected tap SHALL pass through a 2-flop synchronizer plus one delay flop; rising edge = sync & ~delayed.
REQ-020 After MEASURE the FSM SHALL enter DONE for one cycle: count/ovf updated, done=1, ring_en=0; then IDLE.
REQ-021 ring_en SHALL be 1 in SETTLE and MEASURE only.
REQ-022 count and ovf SHALL hold their values from DONE until the next DONE or reset.
REQ-023 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-024 abort in SETTLE or MEASURE SHALL go to IDLE next cycle: ring_en=0, no done pulse, count/ovf unchanged; abort has priority over start and over window expiry.
REQ-025 The window-length counter SHALL be at least 16 bits; gate_log2=0 SHALL give a 1-cycle window.

Reset
REQ-026 While rst_n=0 at a clk edge: state=IDLE, ring_en=0, busy=0, done=0, count=0, ovf=0, synchronizer flops=0.
REQ-027 Reset mid-measurement SHALL discard the measurement with no done pulse.

Configuration
REQ-028 With RINGOSC_MEAS_SAT_EN defined, the edge counter SHALL stop at 2^COUNT_W-1, and ovf SHALL be set in DONE if an increment was suppressed.
REQ-029 Without RINGOSC_MEAS_SAT_EN, the counter SHALL wrap modulo 2^COUNT_W and ovf SHALL be constant 0.

Structure
REQ-030 Package ringosc_pkg SHALL hold the FSM state enum and the default constants for COUNT_W and SETTLE_CYCLES.
REQ-031 Sub-module ringosc_edge_sync SHALL contain the 2-flop synchronizer, the delay flop and the edge detector.

Verification
REQ-032 The bench SHALL cover: tap_sel=2, ring_taps[2] held 0, gate_log2=6 -> busy for 16+64 cycles, done pulse, count=0.
REQ-033 The bench SHALL cover: ring_taps[5] toggling every 4 clk cycles, gate_log2=6 -> count=8±1, ring_en high for exactly 80 cycles.
REQ-034 The bench SHALL cover: COUNT_W=8, tap toggling every clk cycle, gate_log2=10 -> count=255 and ovf=1 with the macro; count=(512±1) mod 256 and ovf=0 without.
REQ-035 The bench SHALL cover: abort asserted 10 cycles into MEASURE -> IDLE next cycle, ring_en=0, no done, previous count retained.
REQ-036 The bench SHALL cover: start pulsed while busy, and start held through DONE -> neither restarts; exactly one done per accepted start.
REQ-037 The bench SHALL cover: rst_n=0 during MEASURE -> all outputs 0 on the next edge, no done pulse.
